wb_timer: RTL

WB_TIMER -- requirements
Module: wb_timer

---
 rtl/wb_timer_if.sv | 15 +
 rtl/wb_timer.sv | 78 +++++++
 2 files changed

// File: rtl/wb_timer_if.sv
// wb_timer_if: Wishbone pipelined bus bundle shared by the timer and its host.
interface wb_if;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [31:0] adr;
  logic [3:0]  sel;
  logic [31:0] dat_m;
  logic [31:0] dat_s;
  logic        ack;
  logic        err;
  logic        stall;
  modport slave (input cyc, stb, we, adr, sel, dat_m, output dat_s, ack, err, stall);
  modport master (output cyc, stb, we, adr, sel, dat_m, input dat_s, ack, err, stall);
endinterface

// File: rtl/wb_timer.sv
// wb_timer: 64-bit machine timer with compare interrupt and prescaler on a Wishbone slave port.
module wb_timer #(
  parameter int          PRESCALE_W = 8,
  parameter logic [63:0] CMP_RESET  = 64'hFFFF_FFFF_FFFF_FFFF
) (
  input  logic clk,
  input  logic rst,
  wb_if.slave  wb,
  output logic irq_timer
);
  localparam logic [31:0] CTRL_MASK = {{(24-PRESCALE_W){1'b0}}, {PRESCALE_W{1'b1}}, 8'h01};
  logic [63:0]           mtime_q, mtime_d, cmp_q, cmp_d;
  logic [31:0]           ctrl_q, ctrl_d, shadow_q, shadow_d, dat_q, dat_d, rdat;
  logic [PRESCALE_W-1:0] pcnt_q, pcnt_d;
  logic                  shadow_v_q, shadow_v_d, ack_q, ack_d, err_q, err_d, irq_q, irq_d;
  logic                  accept, bad, wr, rd, tick;
  logic [2:0]            idx;
  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] s);
    for (int i = 0; i < 4; i++) merge[8*i +: 8] = s[i] ? n[8*i +: 8] : o[8*i +: 8];
  endfunction
  always_comb begin
    accept     = wb.cyc & wb.stb;
    idx        = wb.adr[4:2];
    bad        = (idx[2] & idx[1]) | (idx == 3'd5 & wb.we);
    wr         = accept & wb.we & ~bad & (|wb.sel);
    rd         = accept & ~wb.we & ~bad;
    tick       = ctrl_q[0] & (pcnt_q == ctrl_q[8 +: PRESCALE_W]);
    rdat       = idx == 3'd0 ? mtime_q[31:0] :
                 idx == 3'd1 ? (shadow_v_q ? shadow_q : mtime_q[63:32]) :
                 idx == 3'd2 ? cmp_q[31:0] :
                 idx == 3'd3 ? cmp_q[63:32] :
                 idx == 3'd4 ? ctrl_q : {31'b0, mtime_q >= cmp_q};
    // A bus write to either MTIME word suppresses the increment for the whole counter
    mtime_d    = (wr && idx == 3'd0) ? {mtime_q[63:32], merge(mtime_q[31:0], wb.dat_m, wb.sel)} :
                 (wr && idx == 3'd1) ? {merge(mtime_q[63:32], wb.dat_m, wb.sel), mtime_q[31:0]} :
                 tick ? mtime_q + 64'd1 : mtime_q;
    cmp_d      = (wr && idx == 3'd2) ? {cmp_q[63:32], merge(cmp_q[31:0], wb.dat_m, wb.sel)} :
                 (wr && idx == 3'd3) ? {merge(cmp_q[63:32], wb.dat_m, wb.sel), cmp_q[31:0]} : cmp_q;
    ctrl_d     = (wr && idx == 3'd4) ? merge(ctrl_q, wb.dat_m, wb.sel) & CTRL_MASK : ctrl_q;
    pcnt_d     = (!ctrl_q[0] || tick || (wr && idx == 3'd4 && |wb.sel[3:1])) ? '0 : pcnt_q + PRESCALE_W'(1);
    shadow_d   = (rd && idx == 3'd0) ? mtime_q[63:32] : shadow_q;
    shadow_v_d = (wr && idx[2:1] == 2'b00) ? 1'b0 : (rd && idx == 3'd0) ? 1'b1 : shadow_v_q;
    ack_d      = accept & ~bad;
    err_d      = accept & bad;
    dat_d      = rd ? rdat : 32'd0;
    irq_d      = ctrl_q[0] & (mtime_q >= cmp_q);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      mtime_q    <= '0;
      cmp_q      <= CMP_RESET;
      ctrl_q     <= '0;
      pcnt_q     <= '0;
      shadow_q   <= '0;
      shadow_v_q <= 1'b0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      dat_q      <= '0;
      irq_q      <= 1'b0;
    end else begin
      mtime_q    <= mtime_d;
      cmp_q      <= cmp_d;
      ctrl_q     <= ctrl_d;
      pcnt_q     <= pcnt_d;
      shadow_q   <= shadow_d;
      shadow_v_q <= shadow_v_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
      dat_q      <= dat_d;
      irq_q      <= irq_d;
    end
  end
  assign wb.stall  = 1'b0;
  assign wb.ack    = ack_q;
  assign wb.err    = err_q;
  assign wb.dat_s  = dat_q;
  assign irq_timer = irq_q;
endmodule
